// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving the program counter over a req/ack instruction fetch.
// Optional HALT_DETECT_EN: a taken self-jump parks the sequencer in HALT until reset.
module pc_sequencer #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 16,
  parameter int CINST_BIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] pc_in,
  output logic             inst_req,
  input  logic             inst_ack,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] a_reg,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic             exec_en,
  output logic             pc_load,
  output logic             pc_inc,
  output logic [WIDTH-1:0] pc_data,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  // Handshake: inst_req stays high every FETCH cycle; the cycle with inst_ack=1 completes
  // the fetch and instr/a_reg are captured in that cycle. inst_ack elsewhere is ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             cinst_q;
  logic [2:0]       jump_q;
  logic [WIDTH-1:0] target_q;
  logic             self_q;
  logic             take_now, self_now;
  logic             req_d, exec_d, load_d, inc_d, halt_d;

  // Flags are only valid during EXEC, so the jump decision is resolved from them then.
  assign take_now = cinst_q & ((jump_q[2] & alu_ng) | (jump_q[1] & alu_zr) |
                               (jump_q[0] & ~alu_zr & ~alu_ng));

`ifdef HALT_DETECT_EN
  assign self_now = take_now & (target_q == pc_in);
`else
  assign self_now = 1'b0;
`endif

  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    exec_d  = 1'b0;
    load_d  = 1'b0;
    inc_d   = 1'b0;
    halt_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end
      end
      S_FETCH: begin
        if (inst_ack) begin
          state_d = S_EXEC;
          exec_d  = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_UPDATE;
        load_d  = take_now & ~self_now;
        inc_d   = ~take_now;
      end
      S_UPDATE: begin
        if (self_q) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
        end else if (run) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: halt_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they align with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cinst_q  <= 1'b0;
      jump_q   <= '0;
      target_q <= '0;
      self_q   <= 1'b0;
      inst_req <= 1'b0;
      exec_en  <= 1'b0;
      pc_load  <= 1'b0;
      pc_inc   <= 1'b0;
      pc_data  <= '0;
      halted   <= 1'b0;
      retired  <= '0;
    end else begin
      state_q  <= state_d;
      inst_req <= req_d;
      exec_en  <= exec_d;
      pc_load  <= load_d;
      pc_inc   <= inc_d;
      halted   <= halt_d;
      if (state_q == S_FETCH && inst_ack) begin
        cinst_q  <= instr[CINST_BIT];
        jump_q   <= instr[2:0];
        target_q <= a_reg;
      end
      if (state_q == S_EXEC) self_q <= self_now;
      if (load_d) pc_data <= target_q;
      if (state_q == S_UPDATE && retired != {CNT_W{1'b1}}) retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand sequences and randomized instructions
// checked against a small reference model; a CNT_W=4 twin checks counter saturation.
module tb_pc_sequencer;

`ifdef HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, run, inst_ack, alu_zr, alu_ng;
  logic [15:0] pc_in, instr, a_reg;
  logic        inst_req, exec_en, pc_load, pc_inc, halted;
  logic [15:0] pc_data, retired;
  logic [2:0]  dbg_state;
  logic        inst_req4, exec_en4, pc_load4, pc_inc4, halted4;
  logic [15:0] pc_data4;
  logic [3:0]  retired4;
  logic [2:0]  dbg_state4;

  int checks   = 0;
  int failures = 0;
  int n_retired;
  logic [15:0] exp_pc_data;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .pc_in(pc_in), .inst_req(inst_req),
    .inst_ack(inst_ack), .instr(instr), .a_reg(a_reg), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .exec_en(exec_en), .pc_load(pc_load), .pc_inc(pc_inc), .pc_data(pc_data),
    .halted(halted), .retired(retired), .dbg_state(dbg_state)
  );

  pc_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .pc_in(pc_in), .inst_req(inst_req4),
    .inst_ack(inst_ack), .instr(instr), .a_reg(a_reg), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .exec_en(exec_en4), .pc_load(pc_load4), .pc_inc(pc_inc4), .pc_data(pc_data4),
    .halted(halted4), .retired(retired4), .dbg_state(dbg_state4)
  );

  typedef struct {
    logic [15:0] ins;
    logic [15:0] a;
    bit          zr;
    bit          ng;
    int          dly;
    bit          run_next;
    bit          exp_load;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: the ALU result falls in one category (greater/equal/less) and the jump bit
  // for that category decides; A-instructions never jump.
  function automatic bit model_take(input logic [15:0] ins, input bit zr, input bit ng);
    logic [2:0] j;
    int cat;
    j = ins[2:0];
    if (!ins[15]) return 1'b0;
    cat = ng ? 2 : (zr ? 1 : 0);
    return j[cat];
  endfunction

  function automatic int sat(input int n, input int max);
    return (n > max) ? max : n;
  endfunction

  task automatic reset_dut();
    reset = 1'b1; run = 1'b0; inst_ack = 1'b0; alu_zr = 1'b0; alu_ng = 1'b0;
    instr = 16'h0; a_reg = 16'h0; pc_in = 16'h0;
    tick(); tick();
    reset = 1'b0;
    n_retired = 0;
    exp_pc_data = 16'h0;
  endtask

  // One full instruction: wait for the fetch, ack after dly wait cycles, then check
  // EXEC and UPDATE strobes and the retired count.
  task automatic do_instr(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] pc,
                          input bit zr, input bit ng, input int dly, input bit run_next,
                          output bit got_load);
    int waited;
    bit take, self_j;
    waited = 0;
    run = 1'b1;
    pc_in = pc;
    while (!inst_req && waited < 10) begin
      tick();
      waited++;
    end
    check("req_start", inst_req, 1);
    for (int k = 0; k < dly; k++) begin
      check("req_hold", inst_req, 1);
      inst_ack = 1'b0;
      tick();
    end
    check("req_at_ack", inst_req, 1);
    inst_ack = 1'b1; instr = ins; a_reg = a;
    tick();
    inst_ack = 1'b0; instr = 16'($urandom); a_reg = 16'($urandom);
    check("exec_en", exec_en, 1);
    check("req_in_exec", inst_req, 0);
    check("no_pulse_exec", {pc_load, pc_inc}, 2'b00);
    alu_zr = zr; alu_ng = ng; run = run_next;
    tick();
    take   = model_take(ins, zr, ng);
    self_j = HALT_EN && take && (a == pc);
    if (take && !self_j) exp_pc_data = a;
    got_load = pc_load;
    check("exec_en_off", exec_en, 0);
    check("pc_load", pc_load, take && !self_j);
    check("pc_inc", pc_inc, !take);
    check("pc_data", pc_data, exp_pc_data);
    n_retired++;
    alu_zr = 1'($urandom); alu_ng = 1'b0;
    tick();
    check("retired", retired, sat(n_retired, 16'hFFFF));
    check("retired4", retired4, sat(n_retired, 15));
    check("halted", halted, self_j);
    check("pulse_single", {pc_load, pc_inc}, 2'b00);
    if (self_j || !run_next) check("req_stopped", inst_req, 0);
  endtask

  initial begin
    bit got;
    logic [2:0] masks [8];
    logic [15:0] ra, rpc;
    int cat;

    masks[1] = 3'b001; masks[2] = 3'b100; masks[3] = 3'b101; masks[4] = 3'b010;
    masks[5] = 3'b011; masks[6] = 3'b110; masks[7] = 3'b111; masks[0] = 3'b000;

    // Directed table: {instr, a_reg, zr, ng, ack delay, run after, expected pc_load}
    vecs.push_back('{16'h0005, 16'h1234, 1'b0, 1'b0, 0, 1'b1, 1'b0});
    vecs.push_back('{16'hE302, 16'h002D, 1'b1, 1'b0, 0, 1'b1, 1'b1});
    vecs.push_back('{16'hE302, 16'h002D, 1'b0, 1'b0, 0, 1'b0, 1'b0});
    vecs.push_back('{16'h0007, 16'h0099, 1'b1, 1'b0, 1, 1'b1, 1'b0});
    vecs.push_back('{16'hE307, 16'h4321, 1'b0, 1'b0, 4, 1'b1, 1'b1});
    vecs.push_back('{16'hE300, 16'h5555, 1'b0, 1'b1, 2, 1'b1, 1'b0});
    for (int j = 1; j < 8; j++)
      for (int f = 0; f < 3; f++)
        vecs.push_back('{16'hE300 | 16'(j), 16'(16'h0100 + j * 16 + f), f == 0, f == 1,
                         f, (f != 2), masks[j][2 - f]});

    reset_dut();
    check("rst_req", inst_req, 0);
    check("rst_strobes", {exec_en, pc_load, pc_inc, halted}, 4'b0000);
    check("rst_pc_data", pc_data, 0);
    check("rst_retired", retired, 0);

    foreach (vecs[i]) begin
      do_instr(vecs[i].ins, vecs[i].a, 16'h0200, vecs[i].zr, vecs[i].ng, vecs[i].dly,
               vecs[i].run_next, got);
      check("table_load", got, vecs[i].exp_load);
    end

    // run dropped during EXEC: instruction completes, then no more fetches
    do_instr(16'hE307, 16'h0777, 16'h0300, 1'b0, 1'b0, 0, 1'b0, got);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("idle_no_req", inst_req, 0);
    end

    // Reset while a fetch is outstanding
    run = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("fetch_req", inst_req, 1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    check("midrst_req", inst_req, 0);
    check("midrst_pulse", {pc_load, pc_inc, exec_en}, 3'b000);
    check("midrst_retired", retired, 0);
    check("midrst_retired4", retired4, 0);
    check("midrst_pc_data", pc_data, 0);
    n_retired = 0;
    exp_pc_data = 16'h0;
    tick();
    check("midrst_idle", inst_req, 0);

    // Randomized instructions against the model
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rpc = 16'($urandom);
      if (ra == rpc) rpc = rpc ^ 16'h1;
      cat = $urandom_range(0, 2);
      do_instr(16'($urandom), ra, rpc, cat == 1, cat == 2, $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, got);
    end

    // Self-jump: halts with detection, loops without it
    reset_dut();
    do_instr(16'hEA87, 16'h0010, 16'h0010, 1'b0, 1'b0, 0, 1'b1, got);
    if (HALT_EN) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        check("halt_held", halted, 1);
        check("halt_quiet", {inst_req, exec_en, pc_load, pc_inc}, 4'b0000);
      end
      check("halt_retired", retired, 1);
    end else begin
      do_instr(16'hEA87, 16'h0010, 16'h0010, 1'b0, 1'b0, 0, 1'b0, got);
      check("loop_load", got, 1);
      check("loop_halted", halted, 0);
    end
    reset_dut();
    check("final_halted", halted, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
